rv32i_core: RTL and testbench
=============================

# rv32i_core

Single-cycle RV32I processor with unified on-chip instruction/data memory, a 32-entry register file and a minimal machine-mode CSR file. It is the top-level compute block of the design: the bench preloads memory through a hierarchical path and then only drives clock and reset. The target workload is the riscv-tests `rv32ui-p-*` suite linked at address 0.

## Interface
- Parameters: none. Memory depth is fixed at 65536 words.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- No other ports. All state is observed hierarchically:
  - `memory.m`: memory array.
  - `rs`: register file.
  - `csr`: CSR storage.

## Operation
- ISA: full RV32I.
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LB, LH, LW, LBU, LHU, SB, SH, SW.
  - All OP-IMM and OP instructions.
  - FENCE and FENCE.I execute as NOPs.
- SYSTEM instructions: ECALL, EBREAK, MRET, and CSRRW/CSRRS/CSRRC plus their immediate forms.
- Register file `rs[0..31]`:
  - x0 always reads 0; writes to x0 are discarded.
  - Reads are combinational.
- Arithmetic:
  - All operations are 32-bit with wrap-around.
  - SLT/BLT/BGE compare signed; SLTU/BLTU/BGEU compare unsigned.
  - Shift amount is operand[4:0]; SRA/SRAI sign-fill.
- Memory:
  - Word-organized, 32-bit words, 65536 entries.
  - Word index is addr[17:2]; addr[31:18] is ignored, so accesses alias.
  - Stores use byte enables from addr[1:0] (SB: one lane, SH: lanes 0–1 or 2–3, SW: all four).
  - Loads select and sign- or zero-extend the addressed lane.
  - Misaligned halfword/word accesses ignore the low address bits; no trap is raised.
- CSRs implemented: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mhartid 0xF14.
  - mhartid reads 0 and is read-only.
  - Any other address reads 0 and ignores writes.
  - CSRRS/CSRRC with rs1 = x0 (or zimm = 0) do not write the CSR.
- Traps: ECALL sets mcause = 11, EBREAK sets mcause = 3, an illegal opcode sets mcause = 2.
  - Trap action: mepc ← pc, pc ← {mtvec[31:2], 2'b00}.
  - A trapping instruction does not write rd.
- MRET: pc ← mepc.

## Timing
- One instruction retires per clock: fetch, decode, execute, memory access and write-back all complete in the same cycle.
- Instruction fetch and data load reads are combinational from `memory.m`.
- Stores, register writes, CSR writes and the PC update take effect on the rising clk edge.
- Reset (rst = 0, asynchronous):
  - pc = 0 and x1–x31 = 0.
  - All CSRs = 0.
  - Memory is not cleared, so preloaded contents survive reset.
- Releasing reset mid-program restarts execution at pc 0.
- An instruction that reads and writes the same register reads the old value.
- A load from an address written by the previous instruction returns the new data.

## Configuration
- `RVTEST_EXIT_EN`: simulation-only pass/fail detection.
- When the macro is defined: on an ECALL with a7 (x17) = 93, the core displays `PASS` if gp (x3) = 1, otherwise `FAIL test <gp>>1>`, and then calls `$finish`. The trap is still taken in the same cycle.
- When the macro is not defined: ECALL only traps. The core never ends simulation by itself.

## Structure
- Package `rv32i_pkg` holds:
  - opcode, funct3 and funct7 constants;
  - CSR address constants;
  - mcause codes;
  - the ALU-op enum.
- Sub-module `rv32i_memory`:
  - Must be instantiated as `memory`, with its storage array named `m`, 32 × 65536 words, so bench preload through `core.memory.m` works.
  - Provides one combinational instruction read port, one combinational data read port, and one byte-enabled synchronous write port.
- Decode, ALU, register file and CSR logic stay in the top level.

## Test plan
- Reset and first fetch:
  - Stimulus: hold rst = 0 mid-run, then release.
  - Required: pc = 0 and x5 = 0 while reset is held; after release, the word at address 0 executes on the next edge.
- SLTU / SLT:
  - Stimulus: x1 = 0xFFFFFFFF, x2 = 1.
  - Required: sltu x3,x1,x2 → 0; sltu x3,x2,x1 → 1; slt x3,x1,x2 → 1; sltiu x3,x0,1 → 1.
- x0 write: addi x0,x0,5, then add x4,x0,x0 → x4 = 0.
- Branches and jumps:
  - jal x1,+8 at 0x10 → x1 = 0x14, pc = 0x18.
  - bltu with 1 vs 0xFFFFFFFF → taken.
  - blt with the same operands → not taken.
- Byte/halfword access, after sw of 0x12345678 to 0x100:
  - lb from 0x101 → 0x00000056.
  - lbu from 0x103 → 0x12.
  - sh of 0xBEEF to 0x102, then lw 0x100 → 0xBEEF5678.
  - lh from 0x102 → 0xFFFFBEEF.
- Trap round trip:
  - Stimulus: mtvec = 0x200, ecall at 0x40.
  - Required: pc = 0x200, mepc = 0x40, mcause = 11.
  - Then csrw mepc to 0x44 followed by mret → pc = 0x44.
  - With `RVTEST_EXIT_EN` defined and gp = 1, a7 = 93: PASS is printed and simulation ends.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared constants and types for the rv32i_core slice.
//   - opcode / funct3 / funct7 / funct12 encodings
//   - CSR addresses and the storage index of each implemented CSR
//   - mcause codes
//   - ALU operation enum and the funct3/funct7 -> ALU-op decoder
package rv32i_pkg;

    localparam int unsigned MemWords = 65536;

    // Major opcodes
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpMisc   = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    // Branch funct3
    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    // Load / store funct3
    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;
    localparam logic [2:0] F3Sb  = 3'b000;
    localparam logic [2:0] F3Sh  = 3'b001;

    // ALU funct3
    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Sltu   = 3'b011;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3SrlSra = 3'b101;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;

    // funct7 selecting SUB / SRA
    localparam logic [6:0] F7Alt = 7'b0100000;

    // SYSTEM funct3 / funct12
    localparam logic [2:0]  F3Priv       = 3'b000;
    localparam logic [2:0]  F3Reserved   = 3'b100;
    localparam logic [1:0]  CsrOpRw      = 2'b01;
    localparam logic [1:0]  CsrOpRs      = 2'b10;
    localparam logic [11:0] Funct12Ecall  = 12'h000;
    localparam logic [11:0] Funct12Ebreak = 12'h001;
    localparam logic [11:0] Funct12Mret   = 12'h302;

    // CSR addresses
    localparam logic [11:0] CsrMstatus  = 12'h300;
    localparam logic [11:0] CsrMtvec    = 12'h305;
    localparam logic [11:0] CsrMscratch = 12'h340;
    localparam logic [11:0] CsrMepc     = 12'h341;
    localparam logic [11:0] CsrMcause   = 12'h342;
    localparam logic [11:0] CsrMtval    = 12'h343;
    localparam logic [11:0] CsrMhartid  = 12'hF14;

    // Storage slot of each writable CSR
    localparam int unsigned CsrCount    = 6;
    localparam logic [2:0]  CsrIdxMstatus  = 3'd0;
    localparam logic [2:0]  CsrIdxMtvec    = 3'd1;
    localparam logic [2:0]  CsrIdxMscratch = 3'd2;
    localparam logic [2:0]  CsrIdxMepc     = 3'd3;
    localparam logic [2:0]  CsrIdxMcause   = 3'd4;
    localparam logic [2:0]  CsrIdxMtval    = 3'd5;

    // mcause codes
    localparam logic [31:0] McauseIllegal = 32'd2;
    localparam logic [31:0] McauseEbreak  = 32'd3;
    localparam logic [31:0] McauseEcall   = 32'd11;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluSll,
        AluSlt,
        AluSltu,
        AluXor,
        AluSrl,
        AluSra,
        AluOr,
        AluAnd
    } alu_op_e;

    // SUB only exists for register-register ops; the immediate form of
    // funct3=000 is always ADDI.
    function automatic alu_op_e alu_decode(logic [2:0] f3, logic [6:0] f7, logic is_op);
        alu_op_e op;
        case (f3)
            F3AddSub: op = (is_op && f7 == F7Alt) ? AluSub : AluAdd;
            F3Sll:    op = AluSll;
            F3Slt:    op = AluSlt;
            F3Sltu:   op = AluSltu;
            F3Xor:    op = AluXor;
            F3SrlSra: op = (f7 == F7Alt) ? AluSra : AluSrl;
            F3Or:     op = AluOr;
            default:  op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_if.sv
// rv32i_if: core <-> memory bus.
//   iaddr  word index of the instruction fetch
//   idata  fetched instruction (combinational)
//   daddr  word index of the data access
//   rdata  data read word (combinational)
//   wdata  store data, replicated across lanes
//   be     store byte enables
//   we     store strobe, sampled on the rising clock edge
interface rv32i_if;
    logic [15:0] iaddr;
    logic [31:0] idata;
    logic [15:0] daddr;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;

    modport master (output iaddr, daddr, wdata, be, we, input idata, rdata);
    modport slave  (input iaddr, daddr, wdata, be, we, output idata, rdata);
endinterface

// File: rtl/rv32i_memory.sv
// rv32i_memory: unified 65536 x 32-bit instruction/data memory.
//   clk  write clock
//   bus  slave side of rv32i_if: combinational instruction and data reads,
//        byte-enabled write on the rising edge.
// The array m is not reset so that preloaded contents survive core reset.
module rv32i_memory
    import rv32i_pkg::*;
(
    input logic   clk,
    rv32i_if.slave bus
);

    logic [31:0] m [0:MemWords-1];

    assign bus.idata = m[bus.iaddr];
    assign bus.rdata = m[bus.daddr];

    always_ff @(posedge clk) begin
        if (bus.we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.be[i]) begin
                    m[bus.daddr][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I processor with a minimal M-mode CSR file.
//   clk  system clock, all state updates on the rising edge
//   rst  asynchronous active-low reset (pc, registers and CSRs cleared)
// State is observed hierarchically: memory.m, rs, csr, pc_q.
// Optional macro RVTEST_EXIT_EN: ECALL with a7 = 93 reports PASS/FAIL from gp
// and ends simulation.
module rv32i_core
    import rv32i_pkg::*;
(
    input logic clk,
    input logic rst
);

    rv32i_if bus ();

    rv32i_memory memory (
        .clk (clk),
        .bus (bus)
    );

    logic [31:0] pc_q, pc_d;
    logic [31:0] rs  [0:31];
    logic [31:0] csr [0:CsrCount-1];

    // Decode
    logic [31:0] instr;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;

    assign instr    = bus.idata;
    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign funct7   = instr[31:25];
    assign csr_addr = instr[31:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // rs[0] is never written, so it always reads 0.
    assign rs1_val = rs[rs1];
    assign rs2_val = rs[rs2];

    assign bus.iaddr = pc_q[17:2];

    // ALU
    alu_op_e     alu_op;
    logic [31:0] alu_b, alu_res;

    assign alu_op = alu_decode(funct3, funct7, opcode == OpOp);
    assign alu_b  = (opcode == OpOp) ? rs2_val : imm_i;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            AluAdd:  alu_res = rs1_val + alu_b;
            AluSub:  alu_res = rs1_val - alu_b;
            AluSll:  alu_res = rs1_val << alu_b[4:0];
            AluSlt:  alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            AluSltu: alu_res = {31'b0, rs1_val < alu_b};
            AluXor:  alu_res = rs1_val ^ alu_b;
            AluSrl:  alu_res = rs1_val >> alu_b[4:0];
            AluSra:  alu_res = $unsigned($signed(rs1_val) >>> alu_b[4:0]);
            AluOr:   alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    // Branch compare
    logic br_taken;
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            F3Beq:   br_taken = rs1_val == rs2_val;
            F3Bne:   br_taken = rs1_val != rs2_val;
            F3Blt:   br_taken = $signed(rs1_val) <  $signed(rs2_val);
            F3Bge:   br_taken = $signed(rs1_val) >= $signed(rs2_val);
            F3Bltu:  br_taken = rs1_val <  rs2_val;
            F3Bgeu:  br_taken = rs1_val >= rs2_val;
            default: br_taken = 1'b0;
        endcase
    end

    // Data memory address and load lane extraction
    logic [31:0] mem_addr, ld_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        unused_addr_bits;

    assign mem_addr         = rs1_val + ((opcode == OpStore) ? imm_s : imm_i);
    assign bus.daddr        = mem_addr[17:2];
    assign unused_addr_bits = ^mem_addr[31:18];
    assign ld_half          = mem_addr[1] ? bus.rdata[31:16] : bus.rdata[15:0];

    always_comb begin
        ld_byte = bus.rdata[7:0];
        case (mem_addr[1:0])
            2'd1:    ld_byte = bus.rdata[15:8];
            2'd2:    ld_byte = bus.rdata[23:16];
            2'd3:    ld_byte = bus.rdata[31:24];
            default: ld_byte = bus.rdata[7:0];
        endcase
        case (funct3)
            F3Lb:    ld_val = {{24{ld_byte[7]}}, ld_byte};
            F3Lh:    ld_val = {{16{ld_half[15]}}, ld_half};
            F3Lbu:   ld_val = {24'b0, ld_byte};
            F3Lhu:   ld_val = {16'b0, ld_half};
            default: ld_val = bus.rdata;
        endcase
    end

    // CSR read and read-modify-write value
    logic [31:0] csr_rdata, csr_src, csr_wdata;
    logic [2:0]  csr_idx;
    logic        csr_hit, csr_wr_req;

    always_comb begin
        csr_rdata = '0;
        csr_idx   = CsrIdxMstatus;
        csr_hit   = 1'b1;
        case (csr_addr)
            CsrMstatus:  begin csr_idx = CsrIdxMstatus;  csr_rdata = csr[CsrIdxMstatus];  end
            CsrMtvec:    begin csr_idx = CsrIdxMtvec;    csr_rdata = csr[CsrIdxMtvec];    end
            CsrMscratch: begin csr_idx = CsrIdxMscratch; csr_rdata = csr[CsrIdxMscratch]; end
            CsrMepc:     begin csr_idx = CsrIdxMepc;     csr_rdata = csr[CsrIdxMepc];     end
            CsrMcause:   begin csr_idx = CsrIdxMcause;   csr_rdata = csr[CsrIdxMcause];   end
            CsrMtval:    begin csr_idx = CsrIdxMtval;    csr_rdata = csr[CsrIdxMtval];    end
            // mhartid and unknown addresses read 0 and drop writes
            CsrMhartid:  csr_hit = 1'b0;
            default:     csr_hit = 1'b0;
        endcase
    end

    assign csr_src    = funct3[2] ? {27'b0, rs1} : rs1_val;
    // Set/clear with rs1 = x0 (or zimm = 0) is a pure read.
    assign csr_wr_req = (funct3[1:0] == CsrOpRw) || (rs1 != 5'd0);

    always_comb begin
        case (funct3[1:0])
            CsrOpRw: csr_wdata = csr_src;
            CsrOpRs: csr_wdata = csr_rdata | csr_src;
            default: csr_wdata = csr_rdata & ~csr_src;
        endcase
    end

    // Main execute / next-state
    logic        rd_we, csr_we, trap;
    logic [31:0] rd_wdata, trap_cause;

    always_comb begin
        pc_d       = pc_q + 32'd4;
        rd_we      = 1'b0;
        rd_wdata   = '0;
        csr_we     = 1'b0;
        trap       = 1'b0;
        trap_cause = '0;
        bus.we     = 1'b0;
        bus.be     = '0;
        bus.wdata  = rs2_val;
        case (opcode)
            OpLui:   begin rd_we = 1'b1; rd_wdata = imm_u; end
            OpAuipc: begin rd_we = 1'b1; rd_wdata = pc_q + imm_u; end
            OpJal: begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + 32'd4;
                pc_d     = pc_q + imm_j;
            end
            OpJalr: begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + 32'd4;
                pc_d     = (rs1_val + imm_i) & ~32'd1;
            end
            OpBranch: if (br_taken) pc_d = pc_q + imm_b;
            OpLoad:  begin rd_we = 1'b1; rd_wdata = ld_val; end
            OpStore: begin
                bus.we = 1'b1;
                case (funct3)
                    F3Sb: begin
                        bus.be    = 4'b0001 << mem_addr[1:0];
                        bus.wdata = {4{rs2_val[7:0]}};
                    end
                    F3Sh: begin
                        bus.be    = mem_addr[1] ? 4'b1100 : 4'b0011;
                        bus.wdata = {2{rs2_val[15:0]}};
                    end
                    default: bus.be = 4'b1111;
                endcase
            end
            OpImm, OpOp: begin rd_we = 1'b1; rd_wdata = alu_res; end
            OpMisc: ;
            OpSystem: begin
                if (funct3 == F3Priv) begin
                    case (csr_addr)
                        Funct12Ecall:  begin trap = 1'b1; trap_cause = McauseEcall;  end
                        Funct12Ebreak: begin trap = 1'b1; trap_cause = McauseEbreak; end
                        Funct12Mret:   pc_d = csr[CsrIdxMepc];
                        default:       begin trap = 1'b1; trap_cause = McauseIllegal; end
                    endcase
                end else if (funct3 == F3Reserved) begin
                    trap       = 1'b1;
                    trap_cause = McauseIllegal;
                end else begin
                    rd_we    = 1'b1;
                    rd_wdata = csr_rdata;
                    csr_we   = csr_hit && csr_wr_req;
                end
            end
            default: begin trap = 1'b1; trap_cause = McauseIllegal; end
        endcase
        if (trap) begin
            rd_we = 1'b0;
            pc_d  = {csr[CsrIdxMtvec][31:2], 2'b00};
        end
        // Memory is not reset, so block stores while the core is held.
        if (!rst) bus.we = 1'b0;
    end

    // State
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
            for (int i = 0; i < 32; i++) rs[i] <= '0;
            for (int i = 0; i < CsrCount; i++) csr[i] <= '0;
        end else begin
            pc_q <= pc_d;
            if (rd_we && rd != 5'd0) rs[rd] <= rd_wdata;
            if (trap) begin
                csr[CsrIdxMepc]   <= pc_q;
                csr[CsrIdxMcause] <= trap_cause;
            end else if (csr_we) begin
                csr[csr_idx] <= csr_wdata;
            end
        end
    end

`ifdef RVTEST_EXIT_EN
    always_ff @(posedge clk) begin
        if (rst && trap && trap_cause == McauseEcall && rs[17] == 32'd93) begin
            if (rs[3] == 32'd1) $display("PASS");
            else $display("FAIL test %0d", rs[3] >> 1);
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_rv32i_core.sv
module tb_rv32i_core;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rv32i_core core (
        .clk (clk),
        .rst (rst)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic put(input int addr, input logic [31:0] word);
        core.memory.m[addr >> 2] = word;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) core.memory.m[i] = 32'h00000013;
        put(32'h00, 32'hFFF00093); // addi x1,x0,-1
        put(32'h04, 32'h00100113); // addi x2,x0,1
        put(32'h08, 32'h001131B3); // sltu x3,x2,x1
        put(32'h0C, 32'h0020B1B3); // sltu x3,x1,x2
        put(32'h10, 32'h008000EF); // jal  x1,+8
        put(32'h14, 32'h00700293); // addi x5,x0,7   (skipped)
        put(32'h18, 32'hFFF00093); // addi x1,x0,-1
        put(32'h1C, 32'h0020A1B3); // slt  x3,x1,x2
        put(32'h20, 32'h00103213); // sltiu x4,x0,1
        put(32'h24, 32'h00500013); // addi x0,x0,5
        put(32'h28, 32'h00000233); // add  x4,x0,x0
        put(32'h2C, 32'h00116463); // bltu x2,x1,+8
        put(32'h30, 32'h00900293); // addi x5,x0,9   (skipped)
        put(32'h34, 32'h00114463); // blt  x2,x1,+8
        put(32'h38, 32'h20000393); // addi x7,x0,0x200
        put(32'h3C, 32'h30539073); // csrw mtvec,x7
        put(32'h40, 32'h00000073); // ecall
        put(32'h44, 32'h12345437); // lui  x8,0x12345
        put(32'h48, 32'h67840413); // addi x8,x8,0x678
        put(32'h4C, 32'h10802023); // sw   x8,0x100(x0)
        put(32'h50, 32'h10100483); // lb   x9,0x101(x0)
        put(32'h54, 32'h10304503); // lbu  x10,0x103(x0)
        put(32'h58, 32'h0000C5B7); // lui  x11,0xC
        put(32'h5C, 32'hEEF58593); // addi x11,x11,-273
        put(32'h60, 32'h10B01123); // sh   x11,0x102(x0)
        put(32'h64, 32'h10002603); // lw   x12,0x100(x0)
        put(32'h68, 32'h10201683); // lh   x13,0x102(x0)
        put(32'h6C, 32'h4046D713); // srai x14,x13,4
        put(32'h70, 32'h01C6D793); // srli x15,x13,28
        put(32'h74, 32'h40110833); // sub  x16,x2,x1
        put(32'h78, 32'hFFFFFFFF); // illegal opcode
        put(32'h200, 32'h04400393); // addi x7,x0,0x44
        put(32'h204, 32'h34139073); // csrw mepc,x7
        put(32'h208, 32'h30200073); // mret

        step();
        step();
        chk("reset_pc", core.pc_q, 32'h0);
        chk("reset_x1", core.rs[1], 32'h0);
        rst = 1'b1;

        step(); chk("addi_x1", core.rs[1], 32'hFFFFFFFF);
        chk("first_pc", core.pc_q, 32'h4);
        step(); chk("addi_x2", core.rs[2], 32'h1);
        step(); chk("sltu_small_big", core.rs[3], 32'h1);
        step(); chk("sltu_big_small", core.rs[3], 32'h0);
        step(); chk("jal_link", core.rs[1], 32'h14);
        chk("jal_pc", core.pc_q, 32'h18);
        step(); chk("reload_x1", core.rs[1], 32'hFFFFFFFF);
        step(); chk("slt_signed", core.rs[3], 32'h1);
        step(); chk("sltiu_x0_1", core.rs[4], 32'h1);
        step(); chk("x0_discard", core.rs[0], 32'h0);
        step(); chk("add_x0_x0", core.rs[4], 32'h0);
        step(); chk("bltu_taken_pc", core.pc_q, 32'h34);
        step(); chk("blt_not_taken_pc", core.pc_q, 32'h38);
        chk("skipped_x5", core.rs[5], 32'h0);
        step(); chk("addi_x7", core.rs[7], 32'h200);
        step(); chk("mtvec", core.csr[CsrIdxMtvec], 32'h200);
        step(); chk("ecall_pc", core.pc_q, 32'h200);
        chk("ecall_mepc", core.csr[CsrIdxMepc], 32'h40);
        chk("ecall_mcause", core.csr[CsrIdxMcause], 32'd11);
        step(); chk("handler_x7", core.rs[7], 32'h44);
        step(); chk("csrw_mepc", core.csr[CsrIdxMepc], 32'h44);
        step(); chk("mret_pc", core.pc_q, 32'h44);
        step(); chk("lui_x8", core.rs[8], 32'h12345000);
        step(); chk("addi_x8", core.rs[8], 32'h12345678);
        step(); chk("sw_mem", core.memory.m[16'h0040], 32'h12345678);
        step(); chk("lb_0x101", core.rs[9], 32'h00000056);
        step(); chk("lbu_0x103", core.rs[10], 32'h00000012);
        step(); chk("lui_x11", core.rs[11], 32'h0000C000);
        step(); chk("addi_x11", core.rs[11], 32'h0000BEEF);
        step(); chk("sh_mem", core.memory.m[16'h0040], 32'hBEEF5678);
        step(); chk("lw_after_sh", core.rs[12], 32'hBEEF5678);
        step(); chk("lh_0x102", core.rs[13], 32'hFFFFBEEF);
        step(); chk("srai", core.rs[14], 32'hFFFFFBEE);
        step(); chk("srli", core.rs[15], 32'h0000000F);
        step(); chk("sub", core.rs[16], 32'h00000002);
        chk("pc_before_illegal", core.pc_q, 32'h78);
        step(); chk("illegal_pc", core.pc_q, 32'h200);
        chk("illegal_mcause", core.csr[CsrIdxMcause], 32'd2);
        chk("illegal_mepc", core.csr[CsrIdxMepc], 32'h78);

        // Asynchronous reset mid-run, between clock edges
        step();
        #2 rst = 1'b0;
        #1;
        chk("async_reset_pc", core.pc_q, 32'h0);
        chk("async_reset_x1", core.rs[1], 32'h0);
        chk("async_reset_x16", core.rs[16], 32'h0);
        chk("async_reset_x5", core.rs[5], 32'h0);
        chk("async_reset_mcause", core.csr[CsrIdxMcause], 32'h0);
        chk("reset_keeps_mem", core.memory.m[16'h0040], 32'hBEEF5678);
        step();
        chk("held_reset_pc", core.pc_q, 32'h0);
        rst = 1'b1;
        step();
        chk("restart_x1", core.rs[1], 32'hFFFFFFFF);
        chk("restart_pc", core.pc_q, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
